// File: rtl/fir_filter.sv
// Direct-form FIR filter: NT-tap delay line, registered full-precision products, registered binary adder tree.
// Latency: 2 + ceil(log2(NT)) enabled edges from the capture of a sample to its first appearance on data_out.
// Backpressure: none; ena=0 freezes every pipeline register, and ena=1 advances the whole pipeline one stage.
module fir_filter #(
  parameter int NT          = 8,
  parameter int data_width  = 16,
  parameter int coeff_width = 16
) (
  input  logic                                               clk,
  input  logic                                               resetn,
  input  logic                                               ena,
  input  logic signed [data_width-1:0]                       data_in,
  input  logic        [NT*coeff_width-1:0]                   coeff_concat,
  output logic signed [data_width+coeff_width+$clog2(NT)-1:0] data_out
);

  localparam int DW = data_width;
  localparam int CW = coeff_width;
  localparam int L  = $clog2(NT);
  localparam int PW = DW + CW;
  localparam int OW = PW + L;

  // Number of values present at tree level lv (level 0 = products).
  function automatic int lvl_cnt(input int lv);
    int c;
    c = NT;
    for (int i = 0; i < lv; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Offset of level lv (lv >= 1) inside the flattened tree register array.
  function automatic int lvl_off(input int lv);
    int o;
    o = 0;
    for (int i = 1; i < lv; i++) o += lvl_cnt(i);
    return o;
  endfunction

  localparam int TN = lvl_off(L + 1);

  logic signed [DW-1:0] x_q    [NT];
  logic signed [DW-1:0] x_d    [NT];
  logic signed [CW-1:0] coef   [NT];
  logic signed [PW-1:0] prod_q [NT];
  logic signed [PW-1:0] prod_d [NT];

  // Split the flat coefficient bus into per-tap signed values.
  always_comb begin
    for (int k = 0; k < NT; k++) begin
      coef[k] = coeff_concat[k*CW +: CW];
    end
  end

  // Delay line next state: new sample into tap 0, every tap shifts one place.
  always_comb begin
    x_d[0] = data_in;
    for (int k = 1; k < NT; k++) begin
      x_d[k] = x_q[k-1];
    end
  end

  // Full-precision signed products; coefficients are used live, unregistered.
  always_comb begin
    for (int k = 0; k < NT; k++) begin
      prod_d[k] = PW'(x_q[k]) * PW'(coef[k]);
    end
  end

  // Delay line and product stage registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q    <= '{default: '0};
      prod_q <= '{default: '0};
    end else if (ena) begin
      x_q    <= x_d;
      prod_q <= prod_d;
    end
  end

  if (L == 0) begin : g_direct
    // Single tap: the product register is the output register.
    assign data_out = prod_q[0];
  end else begin : g_tree
    // Level-lv values only ever occupy PW+lv bits; holding them at OW bits is
    // equivalent to sign-extending each adder operand by one bit per level.
    logic signed [OW-1:0] tree_q [TN];
    logic signed [OW-1:0] tree_d [TN];

    for (genvar lv = 1; lv <= L; lv++) begin : g_lvl
      localparam int NIN  = lvl_cnt(lv - 1);
      localparam int NOUT = lvl_cnt(lv);
      localparam int OFF  = lvl_off(lv);
      for (genvar j = 0; j < NOUT; j++) begin : g_node
        logic signed [OW-1:0] opa;
        logic signed [OW-1:0] opb;
        if (lv == 1) begin : g_leaf
          assign opa = OW'(prod_q[2*j]);
          if (2*j + 1 < NIN) begin : g_pair
            assign opb = OW'(prod_q[2*j+1]);
          end else begin : g_pass
            assign opb = '0;
          end
        end else begin : g_inner
          localparam int POFF = lvl_off(lv - 1);
          assign opa = tree_q[POFF + 2*j];
          if (2*j + 1 < NIN) begin : g_pair
            assign opb = tree_q[POFF + 2*j + 1];
          end else begin : g_pass
            assign opb = '0;
          end
        end
        // An unpaired operand is added to zero, i.e. passed through registered.
        assign tree_d[OFF + j] = opa + opb;
      end
    end

    // One register per tree level; all levels advance together on ena.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        tree_q <= '{default: '0};
      end else if (ena) begin
        tree_q <= tree_d;
      end
    end

    // The last node is the single root of the final level.
    assign data_out = tree_q[TN-1];
  end

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: directed table (NT=8) plus random convolution check (NT=1,5,8).
// Latency: expects the first contribution of a sample 2+ceil(log2(NT)) enabled edges after capture.
// Backpressure: exercises ena stalls and asynchronous reset in the middle of a stream.
module tb_fir_filter;

  logic               clk = 1'b0;
  logic               resetn;
  logic               ena;
  logic signed [15:0] data_in;
  logic [8*16-1:0]    coeff8;
  logic [5*16-1:0]    coeff5;
  logic [15:0]        coeff1;
  logic signed [34:0] out8;
  logic signed [34:0] out5;
  logic signed [31:0] out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_filter #(.NT(8), .data_width(16), .coeff_width(16)) u_f8 (
    .clk(clk), .resetn(resetn), .ena(ena), .data_in(data_in),
    .coeff_concat(coeff8), .data_out(out8)
  );
  fir_filter #(.NT(5), .data_width(16), .coeff_width(16)) u_f5 (
    .clk(clk), .resetn(resetn), .ena(ena), .data_in(data_in),
    .coeff_concat(coeff5), .data_out(out5)
  );
  fir_filter #(.NT(1), .data_width(16), .coeff_width(16)) u_f1 (
    .clk(clk), .resetn(resetn), .ena(ena), .data_in(data_in),
    .coeff_concat(coeff1), .data_out(out1)
  );

  typedef struct {
    bit                 rst;
    int                 cs;
    bit                 en;
    logic signed [15:0] din;
    longint             exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input int cs, input bit en, input int din, input longint e);
    vec_t v;
    v.rst = r;
    v.cs  = cs;
    v.en  = en;
    v.din = 16'(din);
    v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // cs 0: c_k = k+1, cs 1: all 3, cs 2: all -32768
  task automatic set_coeffs8(input int cs);
    for (int k = 0; k < 8; k++) begin
      case (cs)
        0:       coeff8[k*16 +: 16] = 16'(k + 1);
        1:       coeff8[k*16 +: 16] = 16'd3;
        default: coeff8[k*16 +: 16] = 16'h8000;
      endcase
    end
  endtask

  // Golden model state for the random phase.
  logic signed [15:0] c8 [8];
  logic signed [15:0] c5 [5];
  logic signed [15:0] c1;
  logic signed [15:0] hist [8];
  longint q8[$];
  longint q5[$];
  longint q1[$];

  task automatic model_clear();
    for (int k = 0; k < 8; k++) hist[k] = '0;
    q8.delete(); q5.delete(); q1.delete();
    for (int k = 0; k < 8; k++) begin
      q8.push_back(0); q5.push_back(0); q1.push_back(0);
    end
  endtask

  task automatic model_step(input logic signed [15:0] din, input int idx);
    longint y8, y5, y1;
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = din;
    y8 = 0;
    y5 = 0;
    for (int k = 0; k < 8; k++) y8 += longint'(c8[k]) * longint'(hist[k]);
    for (int k = 0; k < 5; k++) y5 += longint'(c5[k]) * longint'(hist[k]);
    y1 = longint'(c1) * longint'(hist[0]);
    q8.push_front(y8); q5.push_front(y5); q1.push_front(y1);
    void'(q8.pop_back()); void'(q5.pop_back()); void'(q1.pop_back());
    // Output after this edge reflects the sum formed 1+L edges earlier.
    chk($sformatf("rnd8[%0d]", idx), longint'(out8), q8[4]);
    chk($sformatf("rnd5[%0d]", idx), longint'(out5), q5[4]);
    chk($sformatf("rnd1[%0d]", idx), longint'(out1), q1[1]);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_8"}, longint'(out8), 0);
    chk({nm, "_5"}, longint'(out5), 0);
    chk({nm, "_1"}, longint'(out1), 0);
  endtask

  initial begin
    longint imp_exp[14] = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 0, 0};
    longint dc_exp[13]  = '{0, 0, 0, 0, 300, 600, 900, 1200, 1500, 1800, 2100, 2400, 2400};
    longint ext_exp[13] = '{64'sd0, 64'sd0, 64'sd0, 64'sd0,
                            64'sd1073741824, 64'sd2147483648, 64'sd3221225472, 64'sd4294967296,
                            64'sd5368709120, 64'sd6442450944, 64'sd7516192768, 64'sd8589934592,
                            64'sd8589934592};
    logic signed [15:0] din;

    resetn  = 1'b0;
    ena     = 1'b0;
    data_in = '0;
    coeff8  = '0;
    coeff5  = '0;
    coeff1  = '0;
    #1;
    chk_all_zero("reset_state");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Impulse with c_k = k+1.
    add(1, 0, 1, 0, 0);
    for (int i = 0; i < 14; i++) add(0, 0, 1, (i == 0) ? 1 : 0, imp_exp[i]);

    // Impulse with a 5-cycle stall; din during the stall must be ignored.
    add(1, 0, 1, 0, 0);
    add(0, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 2);
    add(0, 0, 1, 0, 3);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 7, 3);
    add(0, 0, 1, 0, 4);
    add(0, 0, 1, 0, 5);
    add(0, 0, 1, 0, 6);
    add(0, 0, 1, 0, 7);
    add(0, 0, 1, 0, 8);
    add(0, 0, 1, 0, 0);

    // DC: all c_k = 3, constant 100.
    add(1, 1, 1, 0, 0);
    for (int i = 0; i < 13; i++) add(0, 1, 1, 100, dc_exp[i]);

    // Extreme negative operands, no wrap in 35 bits.
    add(1, 2, 1, 0, 0);
    for (int i = 0; i < 13; i++) add(0, 2, 1, -32768, ext_exp[i]);

    // Reset while holding the maximum value must clear immediately.
    add(1, 2, 1, 0, 0);

    foreach (tbl[i]) begin
      set_coeffs8(tbl[i].cs);
      if (tbl[i].rst) begin
        resetn = 1'b0;
        #1;
        chk($sformatf("tbl_rst[%0d]", i), longint'(out8), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
      end else begin
        ena     = tbl[i].en;
        data_in = tbl[i].din;
        @(posedge clk);
        #1;
        chk($sformatf("tbl[%0d]", i), longint'(out8), tbl[i].exp);
      end
    end

    // Random phase: random coefficients on all three instances.
    for (int k = 0; k < 8; k++) begin
      c8[k] = 16'($urandom);
      coeff8[k*16 +: 16] = c8[k];
    end
    for (int k = 0; k < 5; k++) begin
      c5[k] = 16'($urandom);
      coeff5[k*16 +: 16] = c5[k];
    end
    c1     = 16'($urandom);
    coeff1 = c1;
    ena    = 1'b1;
    resetn = 1'b0;
    #1;
    chk_all_zero("rnd_reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_clear();

    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        // Asynchronous pulse away from any clock edge.
        #2;
        resetn = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_clear();
      end
      din     = 16'($urandom);
      data_in = din;
      @(posedge clk);
      #1;
      model_step(din, i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
